// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural NZCV register plus one-cycle branch resolver.
// Resolves B.cond (with forwarding of the ALU flags produced in EX), CBZ, CBNZ
// and unconditional B, and presents the outcome registered on the next cycle.
module flag_branch_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_setflags,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] cbz_operand,
  output logic [3:0]       flags_q,
  output logic             br_done,
  output logic             br_taken,
  output logic             br_fwd
);

  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [1:0] BR_CBZ  = 2'b01;
  localparam logic [1:0] BR_CBNZ = 2'b10;

  logic [3:0] flags_d;
  logic       br_done_d, br_done_q;
  logic       br_taken_d, br_taken_q;
  logic       br_fwd_d, br_fwd_q;

  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       fwd_active;
  logic       flag_we;
  logic       br_ok;
  logic       cond_result;

  // AArch64 condition evaluation on {N,Z,C,V}. Odd codes invert the even base
  // condition, except 1111 which, like 1110, is always true.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'b111) begin
      return 1'b1;
    end
    return base ^ cond[0];
  endfunction

  assign alu_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};

  // Flag forwarding, branch condition and next-state for all registers.
  always_comb begin
    fwd_active  = ex_valid & ex_setflags & ~flush;
    flag_we     = fwd_active & ~stall;
    eff_flags   = fwd_active ? alu_flags : flags_q;
    br_ok       = br_valid & ~flush;
    cond_result = 1'b1;
    case (br_type)
      BR_COND: cond_result = cond_eval(br_cond, eff_flags);
      BR_CBZ:  cond_result = (cbz_operand == '0);
      BR_CBNZ: cond_result = (cbz_operand != '0);
      default: cond_result = 1'b1;
    endcase

    flags_d    = flag_we ? alu_flags : flags_q;
    br_done_d  = br_done_q;
    br_taken_d = br_taken_q;
    br_fwd_d   = br_fwd_q;
    if (!stall) begin
      br_done_d  = br_ok;
      br_taken_d = br_ok & cond_result;
      br_fwd_d   = br_ok & (br_type == BR_COND) & fwd_active;
    end
  end

  // State registers; reset clears everything immediately, without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_fwd_q   <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      br_done_q  <= br_done_d;
      br_taken_q <= br_taken_d;
      br_fwd_q   <= br_fwd_d;
    end
  end

  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;
  assign br_fwd   = br_fwd_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit with hand-computed expectations.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_setflags;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        stall, flush, br_valid;
  logic [1:0]  br_type;
  logic [3:0]  br_cond;
  logic [63:0] cbz_operand;
  logic [3:0]  flags_q;
  logic        br_done, br_taken, br_fwd;

  int n_cmp = 0;
  int n_mis = 0;

  flag_branch_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .stall(stall), .flush(flush), .br_valid(br_valid),
    .br_type(br_type), .br_cond(br_cond), .cbz_operand(cbz_operand),
    .flags_q(flags_q), .br_done(br_done), .br_taken(br_taken), .br_fwd(br_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic chk_all(input string tag, input logic [3:0] f, input logic d,
                         input logic t, input logic w);
    chk({tag, ".flags"}, {4'h0, flags_q}, {4'h0, f});
    chk({tag, ".done"},  {7'h0, br_done}, {7'h0, d});
    chk({tag, ".taken"}, {7'h0, br_taken}, {7'h0, t});
    chk({tag, ".fwd"},   {7'h0, br_fwd}, {7'h0, w});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
    alu_negative = n; alu_zero = z; alu_carry_out = c; alu_overflow = v;
  endtask

  task automatic set_br(input logic vld, input logic [1:0] t, input logic [3:0] c);
    br_valid = vld; br_type = t; br_cond = c;
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_setflags = 0; stall = 0; flush = 0;
    set_alu(0, 0, 0, 0);
    set_br(0, 2'b00, 4'h0);
    cbz_operand = 64'h0;
    #2;
    chk_all("reset_async", 4'b0000, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    chk_all("reset_held", 4'b0000, 0, 0, 0);

    // Flag write: N=0 Z=1 C=1 V=0
    ex_valid = 1; ex_setflags = 1; set_alu(0, 1, 1, 0);
    step();
    chk_all("flag_write", 4'b0110, 0, 0, 0);
    ex_valid = 0; ex_setflags = 0;

    // B.cond against stored flags 0110
    set_br(1, 2'b00, 4'b0000); step(); chk_all("bc_eq", 4'b0110, 1, 1, 0);
    set_br(1, 2'b00, 4'b1011); step(); chk_all("bc_lt", 4'b0110, 1, 0, 0);
    set_br(1, 2'b00, 4'b1000); step(); chk("bc_hi", {7'h0, br_taken}, 8'h0);
    set_br(1, 2'b00, 4'b1001); step(); chk("bc_ls", {7'h0, br_taken}, 8'h1);
    set_br(1, 2'b00, 4'b1010); step(); chk("bc_ge", {7'h0, br_taken}, 8'h1);
    set_br(1, 2'b00, 4'b1100); step(); chk("bc_gt", {7'h0, br_taken}, 8'h0);
    set_br(1, 2'b00, 4'b0001); step(); chk("bc_ne", {7'h0, br_taken}, 8'h0);
    set_br(1, 2'b00, 4'b0010); step(); chk("bc_hs", {7'h0, br_taken}, 8'h1);
    set_br(1, 2'b00, 4'b0110); step(); chk("bc_vs", {7'h0, br_taken}, 8'h0);
    set_br(1, 2'b00, 4'b1111); step(); chk("bc_nv", {7'h0, br_taken}, 8'h1);

    // Clear flags, then forwarded SUBS (N=1 V=0) with B.cond LT
    set_br(0, 2'b00, 4'h0);
    ex_valid = 1; ex_setflags = 1; set_alu(0, 0, 0, 0);
    step();
    chk_all("flags_clear", 4'b0000, 0, 0, 0);
    set_alu(1, 0, 0, 0);
    set_br(1, 2'b00, 4'b1011);
    step();
    chk_all("fwd_lt", 4'b1000, 1, 1, 1);

    // CBZ/CBNZ/B ignore flags and never report forwarding (EX still writes 1000)
    set_br(1, 2'b01, 4'b0000); cbz_operand = 64'h0;
    step(); chk_all("cbz_zero", 4'b1000, 1, 1, 0);
    cbz_operand = 64'h1;
    step(); chk_all("cbz_one", 4'b1000, 1, 0, 0);
    set_br(1, 2'b10, 4'b0000); cbz_operand = 64'h8000_0000_0000_0000;
    step(); chk_all("cbnz_msb", 4'b1000, 1, 1, 0);
    cbz_operand = 64'h0;
    step(); chk_all("cbnz_zero", 4'b1000, 1, 0, 0);
    set_br(1, 2'b11, 4'b0000);
    step(); chk_all("b_uncond", 4'b1000, 1, 1, 0);
    ex_valid = 0; ex_setflags = 0;
    set_br(0, 2'b00, 4'h0);
    step(); chk_all("idle", 4'b1000, 0, 0, 0);

    // Flush beats flag write and branch
    ex_valid = 1; ex_setflags = 1; set_alu(0, 1, 0, 0);
    set_br(1, 2'b11, 4'h0); flush = 1;
    step(); chk_all("flush", 4'b1000, 0, 0, 0);
    flush = 0;

    // Forwarded B.cond MI (N=1 keeps flags 1000), then stall 3 cycles
    set_alu(1, 0, 0, 0); set_br(1, 2'b00, 4'b0100);
    step(); chk_all("fwd_mi", 4'b1000, 1, 1, 1);
    stall = 1; set_alu(0, 1, 0, 0); set_br(0, 2'b00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 4'b1000, 1, 1, 1);
    end
    stall = 0; ex_valid = 0; ex_setflags = 0;
    step(); chk_all("unstall", 4'b1000, 0, 0, 0);

    // Async reset between edges with flags 1111 and br_done=1
    ex_valid = 1; ex_setflags = 1; set_alu(1, 1, 1, 1); set_br(1, 2'b11, 4'h0);
    step(); chk_all("pre_reset", 4'b1111, 1, 1, 0);
    ex_valid = 0; ex_setflags = 0; set_br(0, 2'b00, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("reset_mid", 4'b0000, 0, 0, 0);
    step();
    reset = 1'b0;
    step(); chk_all("post_reset", 4'b0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
